// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction-fetch / data memory port arbiter.
//   arb_state_t : arbiter FSM state (IDLE, GNT_IF, GNT_D)
//   OWN_IF/OWN_D: encoding of which requester wins an arbitration round
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_D  = 2'd2
  } arb_state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, variable-latency memory between the core's
// instruction-fetch port and its data (load/store) port.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   if_req/if_addr           fetch read request, held until if_ack or if_err
//   if_ack/if_err/if_rdata   fetch completion pulse, timeout pulse, read data
//   d_req/d_we/d_addr/d_wdata  data request (read or write), held until done
//   d_ack/d_err/d_rdata      data completion pulse, timeout pulse, read data
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory request
//   mem_ack/mem_rdata        memory completion pulse and read data
//
// Data normally wins; after MAX_DATA_STREAK consecutive data grants taken
// while a fetch was waiting, the fetch is served. A grant that sees no
// mem_ack for TIMEOUT cycles is aborted with an err pulse to its owner.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT         = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic              if_err,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int TCNT_W = $clog2(TIMEOUT);
  localparam int STRK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);
  localparam logic [STRK_W-1:0] STRK_MAX  = STRK_W'(MAX_DATA_STREAK);

  arb_state_t          r_state;
  logic [STRK_W-1:0]   r_streak;
  logic [TCNT_W-1:0]   r_tcnt;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;

  logic w_any_req;
  logic w_winner;
  logic w_last_cycle;
  logic w_done;

  assign w_any_req    = if_req | d_req;
  // Data wins unless a fetch is waiting and data has used up its streak.
  assign w_winner     = (d_req && (!if_req || (r_streak < STRK_MAX))) ? OWN_D : OWN_IF;
  assign w_last_cycle = (r_tcnt == TCNT_LAST);
  assign w_done       = mem_ack | w_last_cycle;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_streak    <= '0;
      r_tcnt      <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_tcnt    <= '0;
            r_mem_req <= 1'b1;
            if (w_winner == OWN_D) begin
              r_state     <= GNT_D;
              r_mem_we    <= d_we;
              r_mem_addr  <= d_addr;
              r_mem_wdata <= d_wdata;
              // Only grants that overtook a waiting fetch count toward the streak.
              if (if_req) begin
                if (r_streak != STRK_MAX) r_streak <= r_streak + 1'b1;
              end else begin
                r_streak <= '0;
              end
            end else begin
              r_state     <= GNT_IF;
              r_mem_we    <= 1'b0;
              r_mem_addr  <= if_addr;
              r_mem_wdata <= '0;
              r_streak    <= '0;
            end
          end else begin
            r_streak <= '0;
          end
        end
        GNT_IF, GNT_D: begin
          // Address/data stay frozen; only completion or timeout releases the port.
          if (w_done) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  // Completion pulses go only to a requester still asserting its request;
  // mem_ack takes priority over a coinciding timeout.
  assign if_ack   = (r_state == GNT_IF) && mem_ack && if_req;
  assign if_err   = (r_state == GNT_IF) && !mem_ack && w_last_cycle && if_req;
  assign d_ack    = (r_state == GNT_D) && mem_ack && d_req;
  assign d_err    = (r_state == GNT_D) && !mem_ack && w_last_cycle && d_req;
  assign if_rdata = if_ack ? mem_rdata : '0;
  assign d_rdata  = d_ack ? mem_rdata : '0;

endmodule
